// File: rtl/game_pkg.sv
// Shared types and constants for the A/B (bulls-and-cows) game datapath.
package game_pkg;

  typedef logic [3:0] digit_t;

  localparam int NUM_DIGITS = 4;
  localparam int HIST_DEPTH = 6;

  // Digit codes at or above this value are placeholders and never match.
  localparam digit_t DIGIT_INVALID_MIN = 4'hA;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } score_state_t;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
  } score_t;

  function automatic logic digit_valid(input digit_t d);
    return d < DIGIT_INVALID_MIN;
  endfunction

endpackage

// File: rtl/digit_matcher.sv
// Scores one guess digit against all four secret digits.
// hit_a: same digit in the same position. hit_b: same digit elsewhere only.
// An invalid guess digit (>= 4'hA) never matches; an invalid secret digit can
// only equal an invalid guess digit, so it never matches either.
module digit_matcher
  import game_pkg::*;
(
  input  logic [3:0]  guess_digit,
  input  logic [1:0]  guess_pos,
  input  logic [15:0] secret,
  output logic        hit_a,
  output logic        hit_b
);

  logic any_other;

  // Compare the guess digit with every secret position.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path infers a latch.
    hit_a     = 1'b0;
    any_other = 1'b0;
    if (digit_valid(guess_digit)) begin
      for (int j = 0; j < NUM_DIGITS; j++) begin
        if (secret[4*j +: 4] == guess_digit) begin
          if (j[1:0] == guess_pos) hit_a = 1'b1;
          else                     any_other = 1'b1;
        end
      end
    end
    // At most one B credit per guess digit, and none when it is already an A.
    hit_b = any_other & ~hit_a;
  end

endmodule

// File: rtl/score_engine.sv
// score_engine: sequential A/B scoring, one guess digit per cycle.
// start -> 4 compare cycles (idx 3..0) -> done pulse with registered counts.
// Optional score history is built when SCORE_HISTORY_EN is defined; without
// it hist_count and hist_rd_data read as zero.
module score_engine
  import game_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        clear,
  input  logic        start,
  input  logic [15:0] Secret,
  input  logic [15:0] Guess,
  output logic        busy,
  output logic        done,
  output logic [2:0]  Count_A_out,
  output logic [2:0]  Count_B_out,
  output logic        win,
  output logic [2:0]  hist_count,
  input  logic [2:0]  hist_rd_idx,
  output logic [5:0]  hist_rd_data
);

  score_state_t state_q;
  logic [1:0]   idx_q;
  logic [15:0]  secret_q;
  logic [15:0]  guess_q;
  logic [2:0]   acc_a_q, acc_b_q;
  logic [2:0]   acc_a_d, acc_b_d;
  logic [2:0]   count_a_q, count_b_q;
  logic         win_q, done_q, busy_q;
  logic         hit_a, hit_b;
  logic         sync_clr;
  logic         score_last;

  // clear is a new-game request and behaves exactly like RESET.
  assign sync_clr   = RESET | clear;
  // Last compare cycle: the accumulators' next values are the final score.
  assign score_last = (state_q == S_CMP) && (idx_q == 2'd0);

  digit_matcher u_matcher (
    .guess_digit (guess_q[{idx_q, 2'b00} +: 4]),
    .guess_pos   (idx_q),
    .secret      (secret_q),
    .hit_a       (hit_a),
    .hit_b       (hit_b)
  );

  assign acc_a_d = acc_a_q + {2'b00, hit_a};
  assign acc_b_d = acc_b_q + {2'b00, hit_b};

  // Scoring FSM with registered status and count outputs.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (sync_clr) begin
      state_q   <= S_IDLE;
      idx_q     <= 2'd0;
      secret_q  <= '0;
      guess_q   <= '0;
      acc_a_q   <= '0;
      acc_b_q   <= '0;
      count_a_q <= '0;
      count_b_q <= '0;
      win_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            secret_q <= Secret;
            guess_q  <= Guess;
            acc_a_q  <= '0;
            acc_b_q  <= '0;
            idx_q    <= 2'd3;
            busy_q   <= 1'b1;
            state_q  <= S_CMP;
          end
        end
        S_CMP: begin
          acc_a_q <= acc_a_d;
          acc_b_q <= acc_b_d;
          idx_q   <= idx_q - 2'd1;
          if (idx_q == 2'd0) begin
            count_a_q <= acc_a_d;
            count_b_q <= acc_b_d;
            win_q     <= (acc_a_d == 3'(NUM_DIGITS));
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign Count_A_out = count_a_q;
  assign Count_B_out = count_b_q;
  assign win         = win_q;

`ifdef SCORE_HISTORY_EN
  score_t     hist_mem_q [HIST_DEPTH];
  logic [2:0] hist_count_q;
  logic       hist_wr;

  // Store each finished score until the buffer is full, then drop further ones.
  assign hist_wr = score_last && (hist_count_q < 3'(HIST_DEPTH));

  // Occupancy counter; clearing it is what empties the history.
  always_ff @(posedge CLK) begin
    if (sync_clr)     hist_count_q <= '0;
    else if (hist_wr) hist_count_q <= hist_count_q + 3'd1;
  end

  // History storage written at the edge that raises done.
  always_ff @(posedge CLK) begin
    // NOTE: storage has no reset; hist_count gates every read so stale entries never show.
    if (hist_wr) hist_mem_q[hist_count_q] <= '{a: acc_a_d, b: acc_b_d};
  end

  assign hist_count   = hist_count_q;
  assign hist_rd_data = (hist_rd_idx < hist_count_q) ? hist_mem_q[hist_rd_idx] : '0;
`else
  // No storage: the read index is folded into a constant-zero expression.
  assign hist_count   = '0;
  assign hist_rd_data = {3'b000, hist_rd_idx & 3'b000};
`endif

endmodule

// File: tb/tb_score_engine.sv
// Scoreboard bench for score_engine: stimulus pushes expected scores,
// a negedge monitor pops and compares them whenever done is seen.
module tb_score_engine;

  logic        CLK = 1'b0;
  logic        RESET, clear, start;
  logic [15:0] Secret, Guess;
  logic        busy, done, win;
  logic [2:0]  Count_A_out, Count_B_out, hist_count, hist_rd_idx;
  logic [5:0]  hist_rd_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic       win;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  logic [5:0] exp_hist[$];
  exp_t       mon_e;

  score_engine dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .clear        (clear),
    .start        (start),
    .Secret       (Secret),
    .Guess        (Guess),
    .busy         (busy),
    .done         (done),
    .Count_A_out  (Count_A_out),
    .Count_B_out  (Count_B_out),
    .win          (win),
    .hist_count   (hist_count),
    .hist_rd_idx  (hist_rd_idx),
    .hist_rd_data (hist_rd_data)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [2:0] exp_hist_count();
`ifdef SCORE_HISTORY_EN
    return 3'(exp_hist.size());
`else
    return 3'd0;
`endif
  endfunction

  // Expected result of a start issued in the current cycle: done 5 cycles later.
  task automatic push_exp(input logic [2:0] ea, input logic [2:0] eb);
    sb_q.push_back('{a: ea, b: eb, win: (ea == 3'd4), cyc: cyc + 5});
    if (exp_hist.size() < 6) exp_hist.push_back({ea, eb});
  endtask

  task automatic run_score(input logic [15:0] s, input logic [15:0] g,
                           input logic [2:0] ea, input logic [2:0] eb);
    Secret = s;
    Guess  = g;
    start  = 1'b1;
    push_exp(ea, eb);
    tick();
    start = 1'b0;
    repeat (6) tick();
  endtask

  // Monitor: compare each done against the scoreboard, flag extra or missing ones.
  always @(negedge CLK) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: done seen at cycle %0d with nothing expected", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("done_cycle", cyc, mon_e.cyc);
        check("count_a", {29'd0, Count_A_out}, {29'd0, mon_e.a});
        check("count_b", {29'd0, Count_B_out}, {29'd0, mon_e.b});
        check("win", {31'd0, win}, {31'd0, mon_e.win});
      end
    end else if (sb_q.size() > 0 && cyc > sb_q[0].cyc) begin
      mon_e = sb_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missed_done: no done by cycle %0d, expected at cycle %0d", cyc, mon_e.cyc);
    end
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Remaining score vectors after the clear test (7 scores in total with the first).
  logic [15:0] tv_s [6] = '{16'h1234, 16'h1234, 16'h1234, 16'hA23F, 16'h1122, 16'h2111};
  logic [15:0] tv_g [6] = '{16'h4321, 16'h5678, 16'h1AF4, 16'hAF23, 16'h1212, 16'h1222};
  logic [2:0]  tv_a [6] = '{3'd0, 3'd0, 3'd2, 3'd0, 3'd2, 3'd0};
  logic [2:0]  tv_b [6] = '{3'd4, 3'd0, 3'd0, 3'd2, 3'd2, 3'd4};

  initial begin
    RESET = 1'b1; clear = 1'b0; start = 1'b0;
    Secret = '0; Guess = '0; hist_rd_idx = '0;
    repeat (3) tick();
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_a",     {29'd0, Count_A_out}, 32'd0);
    check("rst_b",     {29'd0, Count_B_out}, 32'd0);
    check("rst_win",   {31'd0, win}, 32'd0);
    check("rst_hcnt",  {29'd0, hist_count}, 32'd0);
    check("rst_hdata", {26'd0, hist_rd_data}, 32'd0);
    RESET = 1'b0;
    tick();

    // Exact match with cycle-accurate busy window.
    Secret = 16'h1234; Guess = 16'h1234; start = 1'b1;
    push_exp(3'd4, 3'd0);
    check("busy_c0", {31'd0, busy}, 32'd0);
    tick();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("busy_c%0d", k), {31'd0, busy}, 32'd1);
      tick();
    end
    check("busy_c6", {31'd0, busy}, 32'd0);
    tick();
    check("hold_a",   {29'd0, Count_A_out}, 32'd4);
    check("hold_win", {31'd0, win}, 32'd1);

    // start during scoring is ignored; operand change after start has no effect.
    Secret = 16'h1234; Guess = 16'h4321; start = 1'b1;
    push_exp(3'd0, 3'd4);
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; Secret = 16'h5678; Guess = 16'h5678;
    tick();
    start = 1'b0;
    repeat (6) tick();

    // Winning score so the clear check sees non-zero state beforehand.
    run_score(16'h1234, 16'h1234, 3'd4, 3'd0);
    check("pre_clr_hcnt", {29'd0, hist_count}, {29'd0, exp_hist_count()});

    // Abort with clear in cycle 3; no done from the aborted score.
    Secret = 16'h1234; Guess = 16'h1234; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_hist.delete();
    check("clr_busy", {31'd0, busy}, 32'd0);
    check("clr_done", {31'd0, done}, 32'd0);
    check("clr_a",    {29'd0, Count_A_out}, 32'd0);
    check("clr_b",    {29'd0, Count_B_out}, 32'd0);
    check("clr_win",  {31'd0, win}, 32'd0);
    check("clr_hcnt", {29'd0, hist_count}, 32'd0);
    // start in cycle 4 right after clear is accepted.
    run_score(16'h1234, 16'h1356, 3'd1, 3'd1);
    check("hcnt_1", {29'd0, hist_count}, {29'd0, exp_hist_count()});

    for (int i = 0; i < 6; i++) begin
      run_score(tv_s[i], tv_g[i], tv_a[i], tv_b[i]);
      check($sformatf("hcnt_%0d", i + 2), {29'd0, hist_count}, {29'd0, exp_hist_count()});
    end

    // History readback: 6 stored entries in order, out-of-range reads as zero.
    for (int i = 0; i < 8; i++) begin
      logic [5:0] exp_d;
      hist_rd_idx = 3'(i);
      #1;
      exp_d = 6'd0;
`ifdef SCORE_HISTORY_EN
      if (i < exp_hist.size()) exp_d = exp_hist[i];
`endif
      check($sformatf("hist_rd_%0d", i), {26'd0, hist_rd_data}, {26'd0, exp_d});
    end

    repeat (2) tick();
    check("sb_pending", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
